// File: rtl/srm_pkg.sv
// Shared types and constants for the Simple RISC Machine controller.
//   state_e  : controller FSM states
//   insn_e   : decoded instruction class
//   Opc*/Op* : opcode and op field encodings
//   Vsel*    : one-hot writeback select codes
package srm_pkg;

  typedef enum logic [2:0] {
    StWait,
    StDecode,
    StGetA,
    StGetB,
    StExec,
    StWriteRd,
    StWriteImm,
    StErr
  } state_e;

  typedef enum logic [2:0] {
    InsMovImm,
    InsMovReg,
    InsAdd,
    InsCmp,
    InsAnd,
    InsMvn,
    InsUndef
  } insn_e;

  localparam logic [2:0] OpcMov = 3'b110;
  localparam logic [2:0] OpcAlu = 3'b101;

  localparam logic [1:0] OpMovImm = 2'b10;
  localparam logic [1:0] OpMovReg = 2'b00;
  localparam logic [1:0] OpAdd    = 2'b00;
  localparam logic [1:0] OpCmp    = 2'b01;
  localparam logic [1:0] OpAnd    = 2'b10;
  localparam logic [1:0] OpMvn    = 2'b11;

  localparam logic [3:0] VselNone  = 4'b0000;
  localparam logic [3:0] VselMdata = 4'b0001;
  localparam logic [3:0] VselImm   = 4'b0010;
  localparam logic [3:0] VselPc    = 4'b0100;
  localparam logic [3:0] VselC     = 4'b1000;

endpackage

// File: rtl/srm_decoder.sv
// Combinational instruction decoder: field extraction, sign extension and
// classification of the 16-bit instruction word.
//   ir             : instruction register contents
//   rn, rd, rm     : register index fields
//   shift, op      : IR[4:3], IR[12:11]
//   sximm8, sximm5 : IR[7:0], IR[4:0] sign-extended to DW bits
//   insn           : instruction class (InsUndef for unsupported encodings)
module srm_decoder
  import srm_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic [15:0]   ir,
  output logic [2:0]    rn,
  output logic [2:0]    rd,
  output logic [2:0]    rm,
  output logic [1:0]    shift,
  output logic [1:0]    op,
  output logic [DW-1:0] sximm8,
  output logic [DW-1:0] sximm5,
  output insn_e         insn
);

  logic [2:0] opcode;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign shift  = ir[4:3];
  assign rm     = ir[2:0];

  assign sximm8 = {{(DW-8){ir[7]}}, ir[7:0]};
  assign sximm5 = {{(DW-5){ir[4]}}, ir[4:0]};

  always_comb begin
    insn = InsUndef;
    if (opcode == OpcMov) begin
      if (op == OpMovImm)      insn = InsMovImm;
      else if (op == OpMovReg) insn = InsMovReg;
    end else if (opcode == OpcAlu) begin
      case (op)
        OpAdd:   insn = InsAdd;
        OpCmp:   insn = InsCmp;
        OpAnd:   insn = InsAnd;
        default: insn = InsMvn;
      endcase
    end
  end

endmodule

// File: rtl/vdff.sv
// Enable register with synchronous active-high reset (clears to 0).
//   clk, reset : clock and reset
//   en         : load enable
//   d, q       : data in / registered data out, N bits
module vdff #(
  parameter int unsigned N = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/srm_controller.sv
// Simple RISC Machine control unit: instruction register, decoder and the
// multi-cycle FSM that sequences the external datapath.
//   clk, reset      : clock, synchronous active-high reset
//   s, load, in     : start, IR enable, instruction word (honoured only in WAIT)
//   w, done, illegal: idle, end-of-instruction pulse, trapped status
//   readnum/writenum: register indices
//   write/loada/loadb/loadc/loads/asel/bsel/vsel: datapath strobes and selects
//   shift, ALUop    : shifter and ALU controls
//   sximm8, sximm5  : sign-extended immediates
module srm_controller
  import srm_pkg::*;
#(
  parameter int unsigned DW     = 16,
  parameter bit          STRICT = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          s,
  input  logic          load,
  input  logic [15:0]   in,
  output logic          w,
  output logic          done,
  output logic          illegal,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [3:0]    vsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [DW-1:0] sximm8,
  output logic [DW-1:0] sximm5
);

  state_e     state_q, state_d;
  logic [15:0] ir;
  insn_e      insn;
  logic [2:0] rn, rd, rm;
  logic [1:0] op;

  logic       w_d, done_d, illegal_d, write_d, loada_d, loadb_d, loadc_d, loads_d, asel_d;
  logic [2:0] readnum_d, writenum_d;
  logic [3:0] vsel_d;

  vdff #(
    .N (16)
  ) u_ir (
    .clk   (clk),
    .reset (reset),
    .en    (load && (state_q == StWait)),
    .d     (in),
    .q     (ir)
  );

  srm_decoder #(
    .DW (DW)
  ) u_dec (
    .ir     (ir),
    .rn     (rn),
    .rd     (rd),
    .rm     (rm),
    .shift  (shift),
    .op     (op),
    .sximm8 (sximm8),
    .sximm5 (sximm5),
    .insn   (insn)
  );

  // MOV reg must pass B through untouched, so the ALU is forced to ADD.
  assign ALUop = (insn == InsMovReg) ? 2'b00 : op;
  assign bsel  = 1'b0;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait:   if (s) state_d = StDecode;
      StDecode: begin
        case (insn)
          InsMovImm:               state_d = StWriteImm;
          InsMovReg, InsMvn:       state_d = StGetB;
          InsAdd, InsCmp, InsAnd:  state_d = StGetA;
          default:                 state_d = STRICT ? StErr : StWait;
        endcase
      end
      StGetA:     state_d = StGetB;
      StGetB:     state_d = StExec;
      StExec:     state_d = (insn == InsCmp) ? StWait : StWriteRd;
      StWriteRd:  state_d = StWait;
      StWriteImm: state_d = StWait;
      StErr:      state_d = StErr;
      default:    state_d = StWait;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it. IR
  // only changes on the WAIT->DECODE edge, where every IR-dependent output is 0.
  always_comb begin
    w_d        = 1'b0;
    done_d     = 1'b0;
    illegal_d  = 1'b0;
    write_d    = 1'b0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    asel_d     = 1'b0;
    readnum_d  = 3'd0;
    writenum_d = 3'd0;
    vsel_d     = VselNone;
    unique case (state_d)
      StWait: w_d = 1'b1;
      StGetA: begin
        readnum_d = rn;
        loada_d   = 1'b1;
      end
      StGetB: begin
        readnum_d = rm;
        loadb_d   = 1'b1;
      end
      StExec: begin
        asel_d = (insn == InsMovReg) || (insn == InsMvn);
        if (insn == InsCmp) begin
          loads_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          loadc_d = 1'b1;
        end
      end
      StWriteRd: begin
        writenum_d = rd;
        vsel_d     = VselC;
        write_d    = 1'b1;
        done_d     = 1'b1;
      end
      StWriteImm: begin
        writenum_d = rn;
        vsel_d     = VselImm;
        write_d    = 1'b1;
        done_d     = 1'b1;
      end
      StErr:   illegal_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StWait;
      w        <= 1'b1;
      done     <= 1'b0;
      illegal  <= 1'b0;
      write    <= 1'b0;
      loada    <= 1'b0;
      loadb    <= 1'b0;
      loadc    <= 1'b0;
      loads    <= 1'b0;
      asel     <= 1'b0;
      readnum  <= 3'd0;
      writenum <= 3'd0;
      vsel     <= VselNone;
    end else begin
      state_q  <= state_d;
      w        <= w_d;
      done     <= done_d;
      illegal  <= illegal_d;
      write    <= write_d;
      loada    <= loada_d;
      loadb    <= loadb_d;
      loadc    <= loadc_d;
      loads    <= loads_d;
      asel     <= asel_d;
      readnum  <= readnum_d;
      writenum <= writenum_d;
      vsel     <= vsel_d;
    end
  end

endmodule

// File: tb/tb_srm_controller.sv
// Directed bench: dut is DW=16/STRICT=1, dut0 is DW=32/STRICT=0; both share
// the same stimulus.
module tb_srm_controller;

  logic        clk = 1'b0;
  logic        reset, s, load;
  logic [15:0] in;

  logic        w, done, illegal, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]  readnum, writenum;
  logic [3:0]  vsel;
  logic [1:0]  shift, alu_op;
  logic [15:0] sximm8, sximm5;

  logic        w0, done0, illegal0, write0, loada0, loadb0, loadc0, loads0, asel0, bsel0;
  logic [2:0]  readnum0, writenum0;
  logic [3:0]  vsel0;
  logic [1:0]  shift0, alu_op0;
  logic [31:0] sximm80, sximm50;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  srm_controller #(.DW(16), .STRICT(1'b1)) dut (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w), .done(done), .illegal(illegal), .readnum(readnum), .writenum(writenum),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .vsel(vsel), .shift(shift), .ALUop(alu_op),
    .sximm8(sximm8), .sximm5(sximm5)
  );

  srm_controller #(.DW(32), .STRICT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .s(s), .load(load), .in(in),
    .w(w0), .done(done0), .illegal(illegal0), .readnum(readnum0), .writenum(writenum0),
    .write(write0), .loada(loada0), .loadb(loadb0), .loadc(loadc0), .loads(loads0),
    .asel(asel0), .bsel(bsel0), .vsel(vsel0), .shift(shift0), .ALUop(alu_op0),
    .sximm8(sximm80), .sximm5(sximm50)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs and samples both sit 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] word);
    in   = word;
    load = 1'b1;
    s    = 1'b1;
    step();
    load = 1'b0;
    s    = 1'b0;
  endtask

  logic wr_seen;

  initial begin
    reset = 1'b1; s = 1'b0; load = 1'b0; in = 16'h0;
    step(); step();
    reset = 1'b0;
    check("rst_w", w, 1);
    check("rst_done", done, 0);
    check("rst_illegal", illegal, 0);
    check("rst_strobes", {write, loada, loadb, loadc, loads, asel, bsel}, 0);
    check("rst_vsel", vsel, 0);
    check("rst_sximm8", sximm8, 0);

    // MOV R3,#-5
    issue(16'hD3FB);
    check("movi_decode_w", w, 0);
    step();
    check("movi_writenum", writenum, 3);
    check("movi_vsel", vsel, 4'b0010);
    check("movi_write_done", {write, done}, 2'b11);
    check("movi_sximm8", sximm8, 16'hFFFB);
    check("movi_sximm8_dw32", sximm80, 32'hFFFFFFFB);
    step();
    check("movi_back_w", w, 1);
    check("movi_back_done", done, 0);

    // ADD R2,R1,R0 LSL#1
    issue(16'hA148);
    step();
    check("add_geta", {readnum, loada, loadb}, {3'd1, 2'b10});
    step();
    check("add_getb", {readnum, loadb, loada, shift}, {3'd0, 2'b10, 2'b01});
    step();
    check("add_exec", {alu_op, loadc, asel, bsel, write, done}, {2'b00, 5'b10000});
    step();
    check("add_wrd", {writenum, vsel, write, done}, {3'd2, 4'b1000, 2'b11});
    step();
    check("add_back_w", w, 1);

    // CMP R1,R0
    issue(16'hA900);
    wr_seen = write;
    step(); wr_seen |= write;
    step(); wr_seen |= write;
    step(); wr_seen |= write;
    check("cmp_exec", {loads, loadc, done, alu_op}, {3'b101, 2'b01});
    step(); wr_seen |= write;
    check("cmp_back_w", w, 1);
    check("cmp_no_write", wr_seen, 0);

    // MOV R5,R2
    issue(16'hC0A2);
    step();
    check("movr_getb", {readnum, loadb, loada}, {3'd2, 2'b10});
    step();
    check("movr_exec", {asel, alu_op, loadc}, {1'b1, 2'b00, 1'b1});
    step();
    check("movr_wrd", {writenum, vsel, write}, {3'd5, 4'b1000, 1'b1});
    step();
    check("movr_back_w", w, 1);

    // MVN R7,R4
    issue(16'hB8E4);
    step(); step();
    check("mvn_exec", {asel, alu_op, loadc}, {1'b1, 2'b11, 1'b1});
    step();
    check("mvn_wrd", writenum, 7);
    step();

    // Undefined opcode: dut traps, dut0 treats it as a NOP
    issue(16'hE000);
    step();
    check("undef_err", {illegal, w}, 2'b10);
    check("undef_nop_w", w0, 1);
    check("undef_nop_strobes", {write0, loada0, loadb0, loadc0, loads0, done0, illegal0}, 0);
    for (int i = 0; i < 4; i++) begin
      s = i[0];
      load = i[0];
      in = 16'hD3FB;
      step();
      check("err_hold", {illegal, w, write}, 3'b100);
    end
    s = 1'b0; load = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("err_reset", {illegal, w}, 2'b01);

    // Load during GET_B is ignored
    issue(16'hA148);
    step(); step();
    in = 16'hD1FF;
    load = 1'b1;
    step();
    load = 1'b0;
    check("ldign_exec", {alu_op, loadc, sximm8}, {2'b00, 1'b1, 16'h0048});
    step();
    check("ldign_wrd", {writenum, write}, {3'd2, 1'b1});
    step();

    // Reset during EXEC of ADD
    issue(16'hA148);
    step(); step(); step();
    check("rstx_in_exec", loadc, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("rstx_w", {w, write, done}, 3'b100);
    check("rstx_ir", sximm8, 0);

    // DW=32 sign extension of 8'h80
    issue(16'hD080);
    step();
    check("dw32_sximm8", sximm80, 32'hFFFFFF80);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/srm_controller.md
# srm_controller

Parametrised control unit for the Simple RISC Machine. It combines the instruction register, the instruction decoder and the multi-cycle FSM controller that sequences the external datapath for MOV, ADD, CMP, AND and MVN. Datapath width is configurable, and a strictness mode handles undefined opcodes. The CPU top instantiates it beside the datapath; N/V/Z come from the datapath, not from this block.

## Interface
- DW, 16: datapath width (≥16); width of sximm8/sximm5.
- STRICT, 1: 1 = undefined opcode traps to ERR; 0 = undefined opcode is a NOP.
- clk  in  1  rising-edge clock, the only clock.
- reset  in  1  synchronous, active-high reset.
- s  in  1  start; sampled only while w=1.
- load  in  1  instruction register enable; accepted only while w=1.
- in  in  16  instruction word.
- w  out  1  high while idle in WAIT.
- done  out  1  one-cycle pulse in the final state of each legal instruction.
- illegal  out  1  high while in ERR.
- readnum, writenum  out  3  register index, driven from the field selected by the current state.
- write, loada, loadb, loadc, loads, asel, bsel  out  1  datapath strobes and selects.
- vsel  out  4  one-hot writeback select: 0001 mdata, 0010 sximm8, 0100 PC, 1000 C.
- shift, ALUop  out  2  from IR[4:3] and IR[12:11].
- sximm8, sximm5  out  DW  IR[7:0] and IR[4:0], sign-extended.

## Operation
Instruction fields:
- opcode = IR[15:13], op = IR[12:11], Rn = IR[10:8], Rd = IR[7:5], Rm = IR[2:0].
- Legal instructions: 110/10 MOV imm; 110/00 MOV reg; 101/xx ALU (00 ADD, 01 CMP, 10 AND, 11 MVN).

Instruction register:
- Loads `in` when load=1 and the FSM is in WAIT; load is ignored in every other state.

FSM states and transitions:
- WAIT: w=1. Goes to DECODE when s=1.
- DECODE:
  - MOV imm → WRITE_IMM.
  - MOV reg or MVN → GET_B.
  - ADD, CMP or AND → GET_A.
  - Undefined → ERR (STRICT=1) or WAIT (STRICT=0).
- GET_A: readnum=Rn, loada=1. Goes to GET_B.
- GET_B: readnum=Rm, loadb=1. Goes to EXEC.
- EXEC:
  - bsel=0.
  - asel=1 for MOV reg and MVN.
  - ALUop is forced to 00 for MOV reg.
  - CMP: loads=1, loadc=0, done=1, then WAIT.
  - All other instructions: loadc=1, then WRITE_RD.
- WRITE_RD: writenum=Rd, vsel=1000, write=1, done=1. Goes to WAIT.
- WRITE_IMM: writenum=Rn, vsel=0010, write=1, done=1. Goes to WAIT.
- ERR: illegal=1. s and load are ignored; only reset leaves this state.

Output defaults:
- Every strobe, select and index not listed for the current state is 0.
- vsel = 0000 outside the write states.

## Timing
Reset:
- reset=1 at an edge puts the FSM in WAIT and clears IR to 0, in any state.
- reset has priority over s and load.
- Reset values: w=1; done=0; illegal=0; all strobes 0.

Start:
- load and s asserted in the same WAIT cycle: IR captures `in`, and DECODE uses the new word on the next cycle.

Latency (s sampled at edge k; cycles counted to the return to WAIT):
- MOV imm: 3 cycles (DECODE k+1, WRITE_IMM k+2, WAIT k+3).
- MOV reg and MVN: 5 cycles.
- CMP: 5 cycles.
- ADD and AND: 6 cycles.
- Undefined opcode, STRICT=0: 2 cycles, with no write.

Other rules:
- done never asserts together with w.
- s held high keeps the block issuing back-to-back instructions; WAIT lasts one cycle between them.
- sximm8 and sximm5 are combinational from IR and stable for the whole instruction.

## Structure
- Package srm_pkg holds:
  - the state enum;
  - opcode/op constants;
  - vsel one-hot constants.
- Sub-module srm_decoder: combinational field extraction, sign extension (parametrised by DW) and instruction classification.
- The IR reuses the team's existing enable-register primitive, with width 16.

## Test plan
- MOV R3,#-5: in=16'hD3FB, load+s → WRITE_IMM with writenum=3, vsel=0010, sximm8=16'hFFFB, write=1, done=1; w=1 three cycles after s.
- ADD R2,R1,R0 LSL#1: in=16'hA148:
  - GET_A: readnum=1, loada=1.
  - GET_B: readnum=0, loadb=1, shift=01.
  - EXEC: ALUop=00, loadc=1.
  - WRITE_RD: writenum=2, vsel=1000, write=1.
- CMP R1,R0: in=16'hA900 → EXEC with loads=1, loadc=0, done=1; write never asserts; back in WAIT.
- in=16'hE000:
  - STRICT=1 → ERR, illegal=1 held with s toggling; reset → WAIT.
  - STRICT=0 → WAIT two cycles after s, with no strobes.
- load=1 with in=16'hD1FF during GET_B → IR unchanged, instruction completes with its original fields.
- reset asserted during EXEC of an ADD → next cycle w=1, IR=0, no write.
- DW=32 with IR[7:0]=8'h80 → sximm8=32'hFFFFFF80.
